// File: rtl/dsi_line_packer_if.sv
// rtl/dsi_line_packer_if.sv - pixel source and packet byte stream bundle for dsi_line_packer
interface dsi_line_packer_if #(
  parameter int g_pixels_per_clock = 1
);
  localparam int g_pixel_width = 24 * g_pixels_per_clock;

  logic                     pix_fifo_empty_i;
  logic                     pix_fifo_rd_o;
  logic [g_pixel_width-1:0] pix_fifo_pixels_i;
  logic                     pix_vsync_i;
  logic                     pix_next_frame_o;
  logic [7:0]               byte_o;
  logic                     byte_valid_o;
  logic                     byte_ready_i;
  logic                     byte_sop_o;
  logic                     byte_eop_o;

  // packer side
  modport master (
    input  pix_fifo_empty_i, pix_fifo_pixels_i, pix_vsync_i, byte_ready_i,
    output pix_fifo_rd_o, pix_next_frame_o, byte_o, byte_valid_o, byte_sop_o, byte_eop_o
  );

  // pixel source / downstream side
  modport slave (
    output pix_fifo_empty_i, pix_fifo_pixels_i, pix_vsync_i, byte_ready_i,
    input  pix_fifo_rd_o, pix_next_frame_o, byte_o, byte_valid_o, byte_sop_o, byte_eop_o
  );
endinterface

// File: rtl/dsi_line_packer.sv
// rtl/dsi_line_packer.sv - pixel stream to DSI VSS/RGB888 packet bytes; checksum CRC-16 when DSI_PACKER_CRC_EN is defined
module dsi_line_packer #(
  parameter int g_pixels_per_clock = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic [11:0]            h_active_i,
  input  logic [11:0]            v_active_i,
  dsi_line_packer_if.master      bus
);
  localparam int g_pixel_width = 24 * g_pixels_per_clock;
  localparam int c_word_bytes  = 3 * g_pixels_per_clock;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ_FRAME, ST_WAIT_VS_LOW, ST_VSS, ST_LPH, ST_PAYLOAD, ST_CRC
  } state_t;

  state_t                   state;
  logic [1:0]               hdr_idx;     // byte index inside VSS, LPH or CRC
  logic [11:0]              line_cnt;
  logic [11:0]              v_lines;     // v_active_i captured at line header
  logic [15:0]              wc;          // payload byte count of current line
  logic [15:0]              pay_cnt;     // payload bytes already emitted
  logic [11:0]              words_left;  // pixel words not yet requested
  logic [2:0]               word_idx;    // next byte of the current pixel word
  logic [g_pixel_width-1:0] hold_data;
  logic                     hold_valid;
  logic                     rd_pend;     // word requested last cycle, on the bus now
  logic [7:0]               crc_lo;
  logic [7:0]               crc_hi;

  // Hamming ECC over the 24 header bits, top two bits zero
  function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
    logic [7:0] e;
    e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    e[7:6] = 2'b00;
    return e;
  endfunction

  logic                     advance;
  logic                     src_valid;
  logic [g_pixel_width-1:0] src_word;
  logic [7:0]               src_byte;
  logic                     word_last;
  logic                     pay_emit;
  logic                     consume_last;
  logic                     pix_rd;

  // Output register may load when empty or being taken; the word on the
  // FIFO bus is used directly on its arrival cycle so lines stream gaplessly.
  always_comb begin
    int sh;
    advance      = !bus.byte_valid_o || bus.byte_ready_i;
    src_valid    = hold_valid || rd_pend;
    src_word     = rd_pend ? bus.pix_fifo_pixels_i : hold_data;
    sh           = (c_word_bytes - 1 - int'(word_idx)) * 8;
    src_byte     = src_word[sh +: 8];
    word_last    = (word_idx == 3'(c_word_bytes - 1));
    pay_emit     = (state == ST_PAYLOAD) && advance && src_valid;
    consume_last = pay_emit && word_last;
    pix_rd       = (state == ST_PAYLOAD) && !bus.pix_fifo_empty_i &&
                   (words_left != 12'd0) && (!src_valid || consume_last);
  end

  assign bus.pix_fifo_rd_o = pix_rd;

`ifdef DSI_PACKER_CRC_EN
  logic [15:0] crc;

  // reflected CRC-16 (0x8408), one payload byte per call
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // running checksum, restarted at each line header
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc <= 16'hFFFF;
    end else if (!enable_i) begin
      crc <= 16'hFFFF;
    end else if (state == ST_LPH) begin
      crc <= 16'hFFFF;
    end else if (pay_emit) begin
      crc <= crc_step(crc, src_byte);
    end
  end

  assign crc_lo = crc[7:0];
  assign crc_hi = crc[15:8];
`else
  assign crc_lo = 8'h00;
  assign crc_hi = 8'h00;
`endif

  // packet sequencer with registered byte stream and frame request outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i || !enable_i) begin
      state                <= ST_IDLE;
      hdr_idx              <= 2'd0;
      line_cnt             <= 12'd0;
      v_lines              <= 12'd0;
      wc                   <= 16'd0;
      pay_cnt              <= 16'd0;
      words_left           <= 12'd0;
      word_idx             <= 3'd0;
      hold_data            <= '0;
      hold_valid           <= 1'b0;
      rd_pend              <= 1'b0;
      bus.pix_next_frame_o <= 1'b0;
      bus.byte_o           <= 8'h00;
      bus.byte_valid_o     <= 1'b0;
      bus.byte_sop_o       <= 1'b0;
      bus.byte_eop_o       <= 1'b0;
    end else begin
      if (rd_pend) hold_data <= bus.pix_fifo_pixels_i;
      rd_pend    <= pix_rd;
      hold_valid <= src_valid && !consume_last;
      if (pix_rd) words_left <= words_left - 12'd1;
      if (pay_emit) word_idx <= word_last ? 3'd0 : word_idx + 3'd1;

      // taken byte with nothing new to load leaves the register empty
      if (advance) begin
        bus.byte_valid_o <= 1'b0;
        bus.byte_sop_o   <= 1'b0;
        bus.byte_eop_o   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          line_cnt             <= 12'd0;
          bus.pix_next_frame_o <= 1'b1;
          state                <= ST_REQ_FRAME;
        end
        ST_REQ_FRAME: begin
          if (bus.pix_vsync_i) begin
            bus.pix_next_frame_o <= 1'b0;
            state                <= ST_WAIT_VS_LOW;
          end
        end
        ST_WAIT_VS_LOW: begin
          if (!bus.pix_vsync_i) begin
            hdr_idx <= 2'd0;
            state   <= ST_VSS;
          end
        end
        ST_VSS: begin
          if (advance) begin
            bus.byte_valid_o <= 1'b1;
            bus.byte_sop_o   <= (hdr_idx == 2'd0);
            bus.byte_eop_o   <= (hdr_idx == 2'd3);
            case (hdr_idx)
              2'd0:    bus.byte_o <= 8'h01;
              2'd3:    bus.byte_o <= hdr_ecc(24'h000001);
              default: bus.byte_o <= 8'h00;
            endcase
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) state <= ST_LPH;
          end
        end
        ST_LPH: begin
          if (advance) begin
            bus.byte_valid_o <= 1'b1;
            bus.byte_sop_o   <= (hdr_idx == 2'd0);
            hdr_idx          <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0: begin
                bus.byte_o <= 8'h3E;
                wc         <= 16'(h_active_i) * 16'd3;
                v_lines    <= v_active_i;
                words_left <= h_active_i / 12'(g_pixels_per_clock);
                pay_cnt    <= 16'd0;
                word_idx   <= 3'd0;
              end
              2'd1: bus.byte_o <= wc[7:0];
              2'd2: bus.byte_o <= wc[15:8];
              default: begin
                bus.byte_o <= hdr_ecc({wc, 8'h3E});
                state      <= ST_PAYLOAD;
              end
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (pay_emit) begin
            bus.byte_valid_o <= 1'b1;
            bus.byte_o       <= src_byte;
            pay_cnt          <= pay_cnt + 16'd1;
            if (pay_cnt == wc - 16'd1) begin
              hdr_idx <= 2'd0;
              state   <= ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (advance) begin
            bus.byte_valid_o <= 1'b1;
            if (hdr_idx == 2'd0) begin
              bus.byte_o <= crc_lo;
              hdr_idx    <= 2'd1;
            end else begin
              bus.byte_o     <= crc_hi;
              bus.byte_eop_o <= 1'b1;
              hdr_idx        <= 2'd0;
              if (line_cnt == v_lines - 12'd1) begin
                line_cnt             <= 12'd0;
                bus.pix_next_frame_o <= 1'b1;
                state                <= ST_REQ_FRAME;
              end else begin
                line_cnt <= line_cnt + 12'd1;
                state    <= ST_LPH;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/dsi_line_packer.md
# dsi_line_packer

Converts the pixel stream from the test pattern generator or the frame-buffer FIFO into a DSI packet byte stream. It sits directly downstream of the pixel source and upstream of the lane distributor/serializer. Per frame it requests a frame from the source, emits a VSYNC Start short packet, then one RGB888 long packet per line with header ECC and payload checksum.

## Interface
- g_pixels_per_clock, 1, pixels per FIFO word (1 or 2); pixel word width g_pixel_width = 24 × g_pixels_per_clock
- clk_i  in  1  single clock
- rst_n_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  packer enable; low forces ST_IDLE
- h_active_i  in  12  pixels per line (≥1; even when g_pixels_per_clock = 2)
- v_active_i  in  12  lines per frame (≥1)
- pix_fifo_empty_i  in  1  source has no pixel word
- pix_fifo_rd_o  out  1  pop one pixel word
- pix_fifo_pixels_i  in  g_pixel_width  pixel word, valid the cycle after pix_fifo_rd_o
- pix_vsync_i  in  1  source frame-start acknowledge
- pix_next_frame_o  out  1  frame request to source
- byte_o  out  8  packet byte
- byte_valid_o  out  1  byte_o valid
- byte_ready_i  in  1  downstream accepts byte (transfer = valid & ready)
- byte_sop_o  out  1  first byte of packet
- byte_eop_o  out  1  last byte of packet

## Operation
- States: ST_IDLE, ST_REQ_FRAME, ST_WAIT_VS_LOW, ST_VSS, ST_LPH, ST_PAYLOAD, ST_CRC.
- ST_IDLE: enable_i high → clear line counter → ST_REQ_FRAME.
- ST_REQ_FRAME: pix_next_frame_o = 1 until pix_vsync_i sampled high, then pix_next_frame_o = 0 → ST_WAIT_VS_LOW.
- ST_WAIT_VS_LOW: pix_vsync_i low → ST_VSS.
- ST_VSS: short packet 0x01, 0x00, 0x00, ECC; sop on byte 0, eop on byte 3 → ST_LPH.
- ST_LPH: header 0x3E, WC[7:0], WC[15:8], ECC; WC = 3 × h_active_i (16-bit, max 12285); sop on byte 0 → ST_PAYLOAD.
- ST_PAYLOAD: per pixel emit bits [23:16], [15:8], [7:0]; for 2 ppc, pixel [47:24] first. After 3 × h_active_i bytes → ST_CRC.
- ST_CRC: two bytes, low byte first; eop on second. If line counter = v_active_i − 1: clear counter → ST_REQ_FRAME; else increment → ST_LPH.
- ECC: MIPI DSI 6-bit Hamming over the 24 header bits, ECC[7:6] = 0.
- Pixel read: pix_fifo_rd_o = 1 only in ST_PAYLOAD, when !pix_fifo_empty_i, unread words remain in the line, and the one-word holding register is empty or its last byte transfers this cycle. The word is captured on the following cycle. It is never asserted when empty.
- pix_fifo_empty_i during payload inserts bubbles (byte_valid_o = 0); it never corrupts the stream.

## Timing
- Reset and ST_IDLE: pix_fifo_rd_o, pix_next_frame_o, byte_valid_o, byte_sop_o, byte_eop_o = 0; byte_o = 0x00; all counters 0.
- byte_o, sop and eop are held stable while byte_valid_o & !byte_ready_i. byte_valid_o never drops without a transfer, except on enable_i low.
- Back-to-back: with ready held high and the FIFO never empty, one byte per cycle across packet boundaries (VSS→LPH, CRC→LPH). Payload bubbles are at most 1 cycle, only on the first pixel of a line.
- enable_i low at any point: next cycle ST_IDLE, all outputs at reset values, partial packet abandoned (no eop). h_active_i and v_active_i are sampled at ST_LPH byte 0 and must be static within a frame.
- Line and byte counters wrap only at configured sizes. h_active_i = 1 gives a 3-byte payload.

## Configuration
- DSI_PACKER_CRC_EN defined: checksum is CRC-16, polynomial x^16+x^12+x^5+1, LSB-first (reflected 0x8408), init 0xFFFF, no final XOR, over payload bytes only, reinitialized per packet.
- Not defined: checksum bytes are 0x00, 0x00 (the DSI "checksum not computed" value); no CRC logic is synthesized.

## Test plan
- Reset with enable_i = 0 → all outputs 0, no pix_fifo_rd_o; assert enable_i with pix_vsync_i pulsed 2 cycles → pix_next_frame_o drops after vsync. Then bytes 0x01, 0x00, 0x00, 0x07 with sop on 0x01 and eop on 0x07.
- h_active_i = 3, v_active_i = 1, pixels 0x313233, 0x343536, 0x373839, ready always high → 0x3E, 0x09, 0x00, ECC, then "123456789" bytes. With macro: 0x91, 0x6F (eop on 0x6F). Without macro: 0x00, 0x00.
- Same frame with byte_ready_i toggling randomly (50%) → identical byte sequence. Outputs are held during every stall, and there is exactly one FIFO read per pixel.
- pix_fifo_empty_i high for 10 cycles mid-line → byte_valid_o = 0 during the gap, no read issued while empty, stream resumes with the correct next byte.
- v_active_i = 2 → two LPH/payload/CRC packets, then pix_next_frame_o reasserts for the next frame. Deasserting enable_i mid-payload → outputs return to 0 next cycle. Re-enabling restarts with a frame request.
- g_pixels_per_clock = 2, h_active_i = 4 → 2 FIFO reads, WC = 12, bytes of [47:24] before [23:0] per word.
